// File: rtl/mnist_video_block_classifier.sv
// Binarizes an AXI4-Stream luminance stream, packs 4x4 blocks and scores each block
// against ten Wishbone-programmable digit templates; emits one result beat per full block.
module mnist_video_block_classifier #(
    parameter int DATA_WIDTH     = 8,
    parameter int IMG_Y_NUM      = 480,
    parameter int IMG_Y_WIDTH    = 12,
    parameter int MAX_X_NUM      = 1024,
    parameter int TUSER_WIDTH    = 1,
    parameter int S_TDATA_WIDTH  = 8,
    parameter int WB_ADR_WIDTH   = 8,
    parameter int WB_DAT_WIDTH   = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter int INIT_PARAM_TH  = 127,
    parameter int INIT_PARAM_INV = 0
) (
    input  logic                     aresetn,
    input  logic                     aclk,
    input  logic [TUSER_WIDTH-1:0]   s_axi4s_tuser,
    input  logic                     s_axi4s_tlast,
    input  logic [S_TDATA_WIDTH-1:0] s_axi4s_tdata,
    input  logic                     s_axi4s_tvalid,
    output logic                     s_axi4s_tready,
    output logic [TUSER_WIDTH-1:0]   m_axi4s_tuser,
    output logic                     m_axi4s_tlast,
    output logic [3:0]               m_axi4s_tnumber,
    output logic [3:0]               m_axi4s_tcount,
    output logic [9:0]               m_axi4s_tclustering,
    output logic                     m_axi4s_tvalid,
    input  logic                     m_axi4s_tready,
    input  logic                     s_wb_rst_i,
    input  logic                     s_wb_clk_i,
    input  logic [WB_ADR_WIDTH-1:0]  s_wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]  s_wb_dat_i,
    output logic [WB_DAT_WIDTH-1:0]  s_wb_dat_o,
    input  logic                     s_wb_we_i,
    input  logic [WB_SEL_WIDTH-1:0]  s_wb_sel_i,
    input  logic                     s_wb_stb_i,
    output logic                     s_wb_ack_o
);
    localparam int ACC_DEPTH = MAX_X_NUM / 4;
    localparam int ACC_AW    = $clog2(ACC_DEPTH);
    localparam int NUM_CLASS = 10;

    // Wishbone clock/reset are tied to aclk/aresetn by the integrator.
    wire unused_sig = &{1'b0, s_wb_rst_i, s_wb_clk_i, s_wb_dat_i, s_wb_sel_i,
                        s_axi4s_tdata, s_axi4s_tuser, 1'(IMG_Y_NUM)};

    logic [7:0]             th_reg;
    logic                   inv_reg;
    logic [15:0]            tmpl_reg [NUM_CLASS];
    logic [IMG_Y_WIDTH-1:0] x_reg, y_reg;
    logic [15:0]            acc_mem [ACC_DEPTH];

    logic                   m_tvalid_reg, m_tuser_reg, m_tlast_reg;
    logic [3:0]             m_tnumber_reg, m_tcount_reg;
    logic [9:0]             m_tclustering_reg;

    logic                   xfer, wb_wr, pix_bit, blk_done, blk_first;
    logic [IMG_Y_WIDTH-1:0] x_cur, y_cur;
    logic [ACC_AW-1:0]      acc_addr;
    logic [3:0]             bit_idx;
    logic [15:0]            blk_next;
    logic [4:0]             score [NUM_CLASS];
    logic [NUM_CLASS-1:0]   hit;
    logic [4:0]             best_score;
    logic [3:0]             best_class;

    function automatic logic [4:0] popcnt16(input logic [15:0] v);
        logic [4:0] c;
        c = '0;
        for (int i = 0; i < 16; i++) c = c + {4'b0, v[i]};
        return c;
    endfunction

    assign s_axi4s_tready = m_axi4s_tready || !m_tvalid_reg;
    assign xfer           = s_axi4s_tvalid && s_axi4s_tready;

    // Position and block assembly for the pixel currently on the bus.
    always_comb begin
        x_cur     = s_axi4s_tuser[0] ? '0 : x_reg;
        y_cur     = s_axi4s_tuser[0] ? '0 : y_reg;
        pix_bit   = (s_axi4s_tdata[DATA_WIDTH-1:0] > th_reg) ^ inv_reg;
        acc_addr  = x_cur[ACC_AW+1:2];
        bit_idx   = {y_cur[1:0], x_cur[1:0]};
        blk_next  = (bit_idx == 4'd0) ? 16'h0000 : acc_mem[acc_addr];
        blk_next[bit_idx] = pix_bit;
        blk_done  = (x_cur[1:0] == 2'd3) && (y_cur[1:0] == 2'd3);
        blk_first = (x_cur[IMG_Y_WIDTH-1:2] == '0) && (y_cur[IMG_Y_WIDTH-1:2] == '0);
    end

    for (genvar gi = 0; gi < NUM_CLASS; gi++) begin : g_cls
        assign score[gi] = popcnt16(~(blk_next ^ tmpl_reg[gi]));
        assign hit[gi]   = (score[gi] >= 5'd12);
    end

    // Strict greater-than keeps the lowest class index on ties.
    always_comb begin
        best_score = score[0];
        best_class = 4'd0;
        for (int k = 1; k < NUM_CLASS; k++) begin
            if (score[k] > best_score) begin
                best_score = score[k];
                best_class = 4'(k);
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            x_reg <= '0;
            y_reg <= '0;
            for (int i = 0; i < ACC_DEPTH; i++) acc_mem[i] <= '0;
        end else if (xfer) begin
            acc_mem[acc_addr] <= blk_next;
            if (s_axi4s_tlast) begin
                x_reg <= '0;
                y_reg <= y_cur + 1'b1;
            end else begin
                x_reg <= x_cur + 1'b1;
                y_reg <= y_cur;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid_reg      <= 1'b0;
            m_tuser_reg       <= 1'b0;
            m_tlast_reg       <= 1'b0;
            m_tnumber_reg     <= '0;
            m_tcount_reg      <= '0;
            m_tclustering_reg <= '0;
        end else if (xfer && blk_done) begin
            m_tvalid_reg      <= 1'b1;
            m_tuser_reg       <= blk_first;
            m_tlast_reg       <= s_axi4s_tlast;
            m_tnumber_reg     <= best_class;
            m_tcount_reg      <= best_score[4] ? 4'd15 : best_score[3:0];
            m_tclustering_reg <= hit;
        end else if (m_axi4s_tready) begin
            m_tvalid_reg <= 1'b0;
        end
    end

    assign m_axi4s_tvalid      = m_tvalid_reg;
    assign m_axi4s_tuser       = TUSER_WIDTH'(m_tuser_reg);
    assign m_axi4s_tlast       = m_tlast_reg;
    assign m_axi4s_tnumber     = m_tnumber_reg;
    assign m_axi4s_tcount      = m_tcount_reg;
    assign m_axi4s_tclustering = m_tclustering_reg;

    assign s_wb_ack_o = s_wb_stb_i;
    assign wb_wr      = s_wb_stb_i && s_wb_we_i;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            th_reg  <= 8'(INIT_PARAM_TH);
            inv_reg <= 1'(INIT_PARAM_INV);
            for (int k = 0; k < NUM_CLASS; k++) tmpl_reg[k] <= '0;
        end else if (wb_wr) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(0) && s_wb_sel_i[0]) th_reg  <= s_wb_dat_i[7:0];
            if (s_wb_adr_i == WB_ADR_WIDTH'(1) && s_wb_sel_i[0]) inv_reg <= s_wb_dat_i[0];
            for (int k = 0; k < NUM_CLASS; k++) begin
                if (s_wb_adr_i == WB_ADR_WIDTH'(16 + k)) begin
                    if (s_wb_sel_i[0]) tmpl_reg[k][7:0]  <= s_wb_dat_i[7:0];
                    if (s_wb_sel_i[1]) tmpl_reg[k][15:8] <= s_wb_dat_i[15:8];
                end
            end
        end
    end

    always_comb begin
        s_wb_dat_o = '0;
        if (s_wb_adr_i == WB_ADR_WIDTH'(0)) s_wb_dat_o[7:0] = th_reg;
        if (s_wb_adr_i == WB_ADR_WIDTH'(1)) s_wb_dat_o[0]   = inv_reg;
        if (s_wb_adr_i == WB_ADR_WIDTH'(2)) s_wb_dat_o      = WB_DAT_WIDTH'(32'h4D4E4953);
        for (int k = 0; k < NUM_CLASS; k++) begin
            if (s_wb_adr_i == WB_ADR_WIDTH'(16 + k)) s_wb_dat_o[15:0] = tmpl_reg[k];
        end
    end
endmodule

// File: tb/tb_mnist_video_block_classifier.sv
// Bench for mnist_video_block_classifier: directed register/frame cases plus random
// frames compared against a block-level reference model.
module tb_mnist_video_block_classifier;
    logic        clk = 1'b0;
    logic        aresetn;
    logic [0:0]  s_tuser;
    logic        s_tlast, s_tvalid, s_tready;
    logic [7:0]  s_tdata;
    logic [0:0]  m_tuser;
    logic        m_tlast, m_tvalid, m_tready;
    logic [3:0]  m_tnumber, m_tcount;
    logic [9:0]  m_tclustering;
    logic [7:0]  wb_adr;
    logic [31:0] wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel;
    logic        wb_we, wb_stb, wb_ack;

    always #5 clk = ~clk;

    mnist_video_block_classifier dut (
        .aresetn(aresetn), .aclk(clk),
        .s_axi4s_tuser(s_tuser), .s_axi4s_tlast(s_tlast), .s_axi4s_tdata(s_tdata),
        .s_axi4s_tvalid(s_tvalid), .s_axi4s_tready(s_tready),
        .m_axi4s_tuser(m_tuser), .m_axi4s_tlast(m_tlast), .m_axi4s_tnumber(m_tnumber),
        .m_axi4s_tcount(m_tcount), .m_axi4s_tclustering(m_tclustering),
        .m_axi4s_tvalid(m_tvalid), .m_axi4s_tready(m_tready),
        .s_wb_rst_i(~aresetn), .s_wb_clk_i(clk), .s_wb_adr_i(wb_adr),
        .s_wb_dat_i(wb_dat_i), .s_wb_dat_o(wb_dat_o), .s_wb_we_i(wb_we),
        .s_wb_sel_i(wb_sel), .s_wb_stb_i(wb_stb), .s_wb_ack_o(wb_ack)
    );

    typedef struct packed {
        logic       u;
        logic       l;
        logic [3:0] n;
        logic [3:0] c;
        logic [9:0] h;
    } beat_t;

    int          checks = 0;
    int          errors = 0;
    int          beats  = 0;
    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [19:0] obs;
    logic [7:0]  pix [0:63][0:63];
    logic [7:0]  th_m;
    logic        inv_m;
    logic [15:0] tmpl_m [10];

    task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // Reference: each full 4x4 block, scored by counting agreeing template bits.
    task automatic model_frame(input int w, input int h);
        for (int by = 0; by < h / 4; by++) begin
            for (int bx = 0; bx < w / 4; bx++) begin
                logic [15:0] blk;
                beat_t       b;
                int          best, bk, s;
                for (int yy = 0; yy < 4; yy++)
                    for (int xx = 0; xx < 4; xx++)
                        blk[yy*4+xx] = (int'(pix[by*4+yy][bx*4+xx]) > int'(th_m)) ^ inv_m;
                best = -1; bk = 0; b.h = '0;
                for (int k = 0; k < 10; k++) begin
                    s = 0;
                    for (int i = 0; i < 16; i++) if (blk[i] == tmpl_m[k][i]) s++;
                    if (s >= 12) b.h[k] = 1'b1;
                    if (s > best) begin best = s; bk = k; end
                end
                b.n = 4'(bk);
                b.c = (best > 15) ? 4'd15 : 4'(best);
                b.u = (bx == 0 && by == 0);
                b.l = (bx * 4 + 3 == w - 1);
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic send_pixel(input logic [7:0] d, input logic u, input logic l);
        int n;
        s_tdata = d; s_tuser = u; s_tlast = l; s_tvalid = 1'b1;
        for (n = 0; n < 200; n++) begin
            #2;
            if (s_tready) begin
                @(negedge clk);
                break;
            end
            @(negedge clk);
        end
        if (n == 200) begin
            checks++; errors++;
            $error("FAIL input_accept observed=stuck required=accepted");
        end
        s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0;
    endtask

    task automatic send_frame(input int w, input int h, input int extra, input int gap_pct);
        for (int y = 0; y <= h; y++) begin
            for (int x = 0; x < ((y == h) ? extra : w); x++) begin
                send_pixel(pix[y][x], (x == 0 && y == 0), (x == w - 1));
                if ($urandom_range(99) < gap_pct) repeat ($urandom_range(1, 3)) @(negedge clk);
            end
        end
    endtask

    task automatic fill_pix(input logic [7:0] v, input logic rnd);
        for (int y = 0; y < 64; y++)
            for (int x = 0; x < 64; x++)
                pix[y][x] = rnd ? 8'($urandom) : v;
    endtask

    task automatic drain();
        for (int n = 0; n < 300 && exp_q.size() != 0; n++) @(negedge clk);
        check("drain_pending", exp_q.size(), 0);
    endtask

    task automatic wb_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s);
        wb_adr = a; wb_dat_i = d; wb_sel = s; wb_we = 1'b1; wb_stb = 1'b1;
        #2;
        check("wb_ack_write", wb_ack, 1);
        @(negedge clk);
        wb_stb = 1'b0; wb_we = 1'b0;
    endtask

    task automatic wb_read(input logic [7:0] a, input logic [31:0] e, input string tag);
        wb_adr = a; wb_we = 1'b0; wb_stb = 1'b1; wb_sel = 4'hF;
        #2;
        check(tag, wb_dat_o, e);
        check("wb_ack_read", wb_ack, 1);
        @(negedge clk);
        wb_stb = 1'b0;
    endtask

    task automatic set_th(input logic [7:0] v);
        th_m = v;
        wb_write(8'h00, {24'h0, v}, 4'hF);
    endtask

    task automatic set_inv(input logic v);
        inv_m = v;
        wb_write(8'h01, {31'h0, v}, 4'hF);
    endtask

    task automatic set_tmpl(input int k, input logic [15:0] v);
        tmpl_m[k] = v;
        wb_write(8'(16 + k), {16'h0, v}, 4'b0011);
    endtask

    // Output monitor: one comparison per accepted beat, sampled just before the edge.
    always @(negedge clk) begin
        #3;
        if (aresetn && m_tvalid && m_tready) begin
            obs = {m_tuser[0], m_tlast, m_tnumber, m_tcount, m_tclustering};
            beats++;
            $display("beat %0d: num=%0d cnt=%0d clu=%03h user=%0d last=%0d",
                     beats, m_tnumber, m_tcount, m_tclustering, m_tuser[0], m_tlast);
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $error("FAIL beat_unexpected observed=%05h expected=none", obs);
            end else begin
                mon_e = exp_q.pop_front();
                check("beat", {12'h0, obs}, {12'h0, mon_e});
            end
        end
    end

    initial begin
        logic [19:0] held;
        logic        found;
        aresetn = 1'b0; s_tvalid = 1'b0; s_tuser = 1'b0; s_tlast = 1'b0; s_tdata = 8'h0;
        m_tready = 1'b1; wb_adr = 8'h0; wb_dat_i = 32'h0; wb_sel = 4'h0; wb_we = 1'b0; wb_stb = 1'b0;
        th_m = 8'd127; inv_m = 1'b0;
        for (int k = 0; k < 10; k++) tmpl_m[k] = 16'h0;
        repeat (3) @(negedge clk);
        check("rst_m_tvalid", m_tvalid, 0);
        check("rst_m_data", {m_tuser, m_tlast, m_tnumber, m_tcount, m_tclustering}, 0);
        check("rst_s_tready", s_tready, 1);
        aresetn = 1'b1;
        @(negedge clk);

        wb_read(8'h00, 32'd127, "rd_th");
        wb_read(8'h01, 32'd0, "rd_inv");
        wb_read(8'h02, 32'h4D4E4953, "rd_id");
        wb_read(8'h05, 32'h0, "rd_unmapped");
        wb_read(8'h13, 32'h0, "rd_t3_reset");
        wb_write(8'h00, 32'h55, 4'h0);
        wb_read(8'h00, 32'd127, "rd_th_nosel");
        set_tmpl(2, 16'hABCD);
        wb_write(8'h12, 32'h1234, 4'b0001);
        tmpl_m[2] = 16'hAB34;
        wb_read(8'h12, 32'hAB34, "rd_t2_bytesel");
        wb_write(8'h05, 32'hFFFF_FFFF, 4'hF);
        wb_read(8'h05, 32'h0, "rd_unmapped_wr");

        // All-200 frame: only T_3 matches.
        for (int k = 0; k < 10; k++) set_tmpl(k, (k == 3) ? 16'hFFFF : 16'h0000);
        fill_pix(8'd200, 1'b0);
        model_frame(8, 4); send_frame(8, 4, 0, 0); drain();
        set_inv(1'b1);
        model_frame(8, 4); send_frame(8, 4, 0, 0); drain();
        set_inv(1'b0);

        // Threshold boundary: 127 is not above 127, 128 is.
        for (int k = 0; k < 10; k++) set_tmpl(k, (k == 5) ? 16'h0000 : 16'hFFFF);
        fill_pix(8'd127, 1'b0);
        model_frame(8, 4); send_frame(8, 4, 0, 10); drain();
        fill_pix(8'd128, 1'b0);
        model_frame(8, 4); send_frame(8, 4, 0, 10); drain();

        // Output stall: first beat must hold while input is blocked.
        fill_pix(8'd0, 1'b1);
        model_frame(8, 8);
        fork
            send_frame(8, 8, 0, 0);
            begin
                m_tready = 1'b0;
                found = 1'b0;
                for (int n = 0; n < 300 && !found; n++) begin
                    @(negedge clk); #3;
                    found = m_tvalid;
                end
                check("stall_beat_seen", found, 1);
                held = {m_tuser[0], m_tlast, m_tnumber, m_tcount, m_tclustering};
                for (int n = 0; n < 10; n++) begin
                    @(negedge clk); #3;
                    check("stall_hold", {m_tvalid, m_tuser[0], m_tlast, m_tnumber, m_tcount, m_tclustering},
                          {1'b1, held});
                    check("stall_s_tready", s_tready, 0);
                end
                @(negedge clk);
                m_tready = 1'b1;
            end
        join
        drain();

        // Abandoned frame, then tuser restart mid-row.
        fill_pix(8'd0, 1'b1);
        model_frame(8, 4); send_frame(8, 5, 3, 0);
        fill_pix(8'd0, 1'b1);
        model_frame(8, 4); send_frame(8, 4, 0, 0); drain();

        for (int it = 0; it < 16; it++) begin
            int w, h;
            w = 4 * $urandom_range(1, 8) + $urandom_range(0, 3);
            h = $urandom_range(4, 13);
            set_th(8'($urandom));
            set_inv(1'($urandom));
            for (int k = 0; k < 10; k++) set_tmpl(k, 16'($urandom));
            fill_pix(8'd0, 1'b1);
            model_frame(w, h); send_frame(w, h, 0, 20); drain();
        end

        repeat (5) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
